regbank_master: RTL

Command-driven initiator for the 32x32 register bank: accepts read/write/ALU/clear commands on a valid/ready interface and sequences the bank's sr1/sr2/dr/wrData/write pins.
- Bank has combinational reads and a posedge write.
- Returns read data or results on a valid/ready response channel.
- Sits between a control unit or test host and the register bank.

---
 rtl/regbank_pkg.sv | 29 ++
 rtl/regbank_master_if.sv | 32 +++
 rtl/regbank_alu.sv | 24 ++
 rtl/regbank_master.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types for the register-bank command master: op/ALU codes, FSM states, default widths.
package regbank_pkg;

  localparam int REGBANK_DATA_W = 32;
  localparam int REGBANK_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ALU   = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_CLR  = 3'd3,
    S_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/regbank_master_if.sv
// Command/response channel of the register-bank master; the host uses 'master', the block uses 'slave'.
interface regbank_master_if
  import regbank_pkg::*;
#(
  parameter int DATA_W = REGBANK_DATA_W,
  parameter int ADDR_W = REGBANK_ADDR_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_alu;
  logic [ADDR_W-1:0] cmd_sr1;
  logic [ADDR_W-1:0] cmd_sr2;
  logic [ADDR_W-1:0] cmd_dr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;

  modport master (
    output cmd_valid, cmd_op, cmd_alu, cmd_sr1, cmd_sr2, cmd_dr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data1, rsp_data2
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_alu, cmd_sr1, cmd_sr2, cmd_dr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data1, rsp_data2
  );

endinterface

// File: rtl/regbank_alu.sv
// Combinational ALU for the register-bank master; ADD/SUB wrap silently modulo 2**DATA_W.
module regbank_alu
  import regbank_pkg::*;
#(
  parameter int DATA_W = REGBANK_DATA_W
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regbank_master.sv
// Command-driven initiator for the 32x32 register bank (READ/WRITE/ALU/CLEAR over valid/ready).
// Optional build macro REGBANK_MASTER_ZERO_REG_EN makes register 0 read-only zero for WRITE/ALU.
module regbank_master
  import regbank_pkg::*;
#(
  parameter int DATA_W    = REGBANK_DATA_W,
  parameter int ADDR_W    = REGBANK_ADDR_W,
  parameter int REG_COUNT = 32
) (
  input  logic              clk,
  input  logic              reset,
  regbank_master_if.slave   cmd_bus,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] wrData,
  output logic              write,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  state_t            state;
  state_t            state_nxt;
  op_t               op_q;
  alu_op_t           alu_q;
  logic [DATA_W-1:0] rsp_data1_q;
  logic [DATA_W-1:0] rsp_data2_q;
  logic [DATA_W-1:0] alu_result;
  logic              cmd_fire;
  logic              wr_allowed;

  // Ready is gated by reset so the host sees 0 while the block is held in reset.
  assign cmd_bus.cmd_ready = (state == S_IDLE) && reset;
  assign cmd_fire          = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
  assign cmd_bus.rsp_valid = (state == S_RESP);
  assign cmd_bus.rsp_data1 = rsp_data1_q;
  assign cmd_bus.rsp_data2 = rsp_data2_q;

`ifdef REGBANK_MASTER_ZERO_REG_EN
  assign wr_allowed = (dr != '0);
`else
  assign wr_allowed = 1'b1;
`endif

  regbank_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_q),
    .a      (rdData1),
    .b      (rdData2),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // write decodes from state only, so it falls the instant reset asserts.
  always_comb begin
    state_nxt = state;
    write     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          case (op_t'(cmd_bus.cmd_op))
            OP_READ:  state_nxt = S_RD;
            OP_ALU:   state_nxt = S_RD;
            OP_WRITE: state_nxt = S_WR;
            OP_CLEAR: state_nxt = S_CLR;
            default:  state_nxt = S_IDLE;
          endcase
        end
      end
      S_RD: begin
        state_nxt = (op_q == OP_ALU) ? S_WR : S_RESP;
      end
      S_WR: begin
        write     = wr_allowed;
        state_nxt = S_RESP;
      end
      S_CLR: begin
        write = 1'b1;
        if (dr == LAST_IDX) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (cmd_bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bank pins and response words are all registered; dr doubles as the CLEAR walk counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_READ;
      alu_q       <= ALU_ADD;
      sr1         <= '0;
      sr2         <= '0;
      dr          <= '0;
      wrData      <= '0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            op_q  <= op_t'(cmd_bus.cmd_op);
            alu_q <= alu_op_t'(cmd_bus.cmd_alu);
            case (op_t'(cmd_bus.cmd_op))
              OP_READ: begin
                sr1 <= cmd_bus.cmd_sr1;
                sr2 <= cmd_bus.cmd_sr2;
              end
              OP_WRITE: begin
                dr          <= cmd_bus.cmd_dr;
                wrData      <= cmd_bus.cmd_data;
                rsp_data1_q <= cmd_bus.cmd_data;
                rsp_data2_q <= '0;
              end
              OP_ALU: begin
                sr1 <= cmd_bus.cmd_sr1;
                sr2 <= cmd_bus.cmd_sr2;
                dr  <= cmd_bus.cmd_dr;
              end
              OP_CLEAR: begin
                dr          <= '0;
                wrData      <= '0;
                rsp_data1_q <= '0;
                rsp_data2_q <= '0;
              end
              default: begin
                dr <= dr;
              end
            endcase
          end
        end
        S_RD: begin
          if (op_q == OP_ALU) begin
            wrData      <= alu_result;
            rsp_data1_q <= alu_result;
            rsp_data2_q <= '0;
          end else begin
            rsp_data1_q <= rdData1;
            rsp_data2_q <= rdData2;
          end
        end
        S_CLR: begin
          if (dr != LAST_IDX) begin
            dr <= dr + ADDR_W'(1);
          end
        end
        default: begin
          dr <= dr;
        end
      endcase
    end
  end

endmodule
